led_seq_monitor: RTL and testbench
==================================

# led_seq_monitor

Reader-side companion to the bound flasher. Samples the 16-bit LED bus each clock, decodes the thermometer pattern into a lit count, tracks direction, and reports turn points, kickbacks and completed sweeps. Flags illegal codes and illegal steps with sticky error bits. Sits beside the flasher in the lab top level and in the bench as a synthesizable self-check.

## Interface
- WIDTH, 16: LED bus width; lit count range 0..WIDTH.
- CW, 5: count width, $clog2(WIDTH+1).
- SW, 8: sweep counter width.

- clk  in  1  rising-edge clock, same clock as the flasher.
- rst_n  in  1  asynchronous, active-low reset.
- led  in  WIDTH  LED bus from the flasher.
- clear_err  in  1  synchronous clear of err_code/err_step.
- count  out  CW  decoded lit count of last valid sample.
- dir  out  2  0 IDLE, 1 UP, 2 DOWN.
- turn  out  1  one-cycle pulse on direction reversal.
- turn_level  out  CW  count at the extreme where the reversal occurred; holds until next turn.
- kickback  out  1  one-cycle pulse on a DOWN→UP reversal with turn_level > 0.
- sweep_done  out  1  one-cycle pulse when count reaches 0 from 1 while DOWN.
- sweeps  out  SW  completed sweeps, saturating at all-ones.
- err_code  out  1  sticky: a sample was not a thermometer code.
- err_step  out  1  sticky: an illegal count step occurred.

## Operation
- Valid code: led == (1<<n)-1 for n in 0..WIDTH (ones contiguous from bit 0). n = decoded count.
- Invalid code: err_code set; count, dir, all other state hold; no step check that cycle; next valid sample is compared against held count.
- Step rules on valid sample, delta = n - count:
  - delta = +1: if dir IDLE or UP → dir UP. If dir DOWN → turn, turn_level = count, dir UP, kickback if count > 0.
  - delta = −1: if dir UP → turn, turn_level = count, dir DOWN. If dir DOWN → stay DOWN. If dir IDLE → err_step (impossible from 0).
  - delta = 0: legal only at count 0 → dir IDLE. Otherwise err_step, dir holds.
  - |delta| > 1: err_step; count still updates to n, dir holds, no pulses.
- On reaching n = 0 via delta −1: sweep_done pulses, sweeps increments (saturating), dir becomes IDLE (not DOWN). Subsequent +1 from 0 is not a turn.
- Reaching n = WIDTH: dir stays UP; the following −1 produces the turn with turn_level = WIDTH.
- clear_err clears both sticky bits; a new error in the same cycle wins (bit set).

## Timing
- Two register stages: led registered into led_q at edge k; decode and state update registered at edge k+1. Latency from led change to outputs: 2 clocks.
- turn, kickback, sweep_done are single-cycle pulses aligned with the count update that caused them.
- Reset (async assert, sync-safe deassert handled by top): led_q = 0, count = 0, dir = IDLE, turn_level = 0, sweeps = 0, all pulses and error bits 0.
- Reset mid-sweep discards history; first sample after reset is checked against count = 0, so a non-zero first sample > 1 raises err_step.

## Structure
- Shared package bf_pkg: dir_t enum (DIR_IDLE, DIR_UP, DIR_DOWN), LED_WIDTH = 16 constant, shared with the flasher.
- One sub-module: thermo_decode (combinational, led → count + valid). Remainder (step check, direction FSM, counters, sticky errors) in led_seq_monitor.

## Test plan
- Reset with led = 0 held → after 2 clocks count = 0, dir = IDLE, sweeps = 0, no errors.
- Ramp 0x0000…0xFFFF then back down to 0x0000 → count 0..16..0, dir UP then DOWN, turn once with turn_level = 16, sweep_done once, sweeps = 1.
- Ramp to 0x003F (6), step down to 0x001F, rise again → first turn turn_level = 6, second turn turn_level = 5 with kickback = 1.
- Inject 0x0005 mid-ramp at count 3 → err_code = 1, count holds 3; next sample 0x000F accepted as legal +1.
- Jump 0x0003 → 0x00FF → err_step = 1, count = 8; assert clear_err alone → both errors 0; clear_err with a new jump same cycle → err_step stays 1.
- Assert rst_n low mid-ramp at count 9 → all outputs return to reset values immediately; sweeps = 0.

Source files
------------

// File: rtl/bf_pkg.sv
// bf_pkg: shared LED-bus width and direction type used by the flasher and its monitor.
// Contents: LED_WIDTH (bus width), dir_t (IDLE/UP/DOWN sweep direction).
package bf_pkg;
    localparam int LED_WIDTH = 16;
    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;
endpackage

// File: rtl/led_seq_monitor_thermo_decode.sv
// thermo_decode: combinational thermometer-code decoder for the LED bus.
// Ports: led (in, WIDTH) raw bus; count (out, CW) number of lit LEDs; valid (out) ones are contiguous from bit 0.
module thermo_decode #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] led,
    output logic [CW-1:0]    count,
    output logic             valid
);
    // A thermometer code plus one is a single power of two, so the AND is zero;
    // all-ones wraps to zero and passes too.
    assign valid = (led & (led + WIDTH'(1))) == '0;
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) count = count + CW'(led[i]);
    end
endmodule

// File: rtl/led_seq_monitor.sv
// led_seq_monitor: decodes the flasher's LED bus and checks its sweep sequence.
// Ports: clk, rst_n (async active-low), led (bus in), clear_err (sync clear of sticky errors);
// outputs count, dir, turn/turn_level, kickback, sweep_done, sweeps, err_code, err_step.
module led_seq_monitor
    import bf_pkg::*;
#(
    parameter int WIDTH = LED_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int SW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] led,
    input  logic             clear_err,
    output logic [CW-1:0]    count,
    output logic [1:0]       dir,
    output logic             turn,
    output logic [CW-1:0]    turn_level,
    output logic             kickback,
    output logic             sweep_done,
    output logic [SW-1:0]    sweeps,
    output logic             err_code,
    output logic             err_step
);
    logic [WIDTH-1:0] led_q;
    logic [CW-1:0]    n, count_n, tl_n;
    logic [SW-1:0]    sweeps_n;
    logic             valid, up, dn, same, turn_n, kick_n, sd_n, step_e;
    dir_t             dir_r, dir_n;

    thermo_decode #(.WIDTH(WIDTH), .CW(CW)) u_dec (.led(led_q), .count(n), .valid(valid));

    assign dir  = dir_r;
    assign up   = n == count + CW'(1);
    assign dn   = count != '0 && n == count - CW'(1);
    assign same = n == count;

    always_comb begin
        dir_n    = dir_r;
        count_n  = count;
        tl_n     = turn_level;
        sweeps_n = sweeps;
        turn_n   = 1'b0;
        kick_n   = 1'b0;
        sd_n     = 1'b0;
        step_e   = 1'b0;
        if (valid) begin
            // Count follows every valid sample, even an illegal step, so the
            // next step is judged against what the bus actually showed.
            count_n = n;
            if (up) begin
                turn_n = dir_r == DIR_DOWN;
                kick_n = dir_r == DIR_DOWN && count != '0;
                tl_n   = dir_r == DIR_DOWN ? count : turn_level;
                dir_n  = DIR_UP;
            end else if (dn) begin
                step_e = dir_r == DIR_IDLE;
                turn_n = dir_r == DIR_UP;
                tl_n   = dir_r == DIR_UP ? count : turn_level;
                dir_n  = dir_r == DIR_IDLE ? DIR_IDLE : (n == '0 ? DIR_IDLE : DIR_DOWN);
                // Landing on zero ends the sweep; IDLE there keeps the next +1 from counting as a turn.
                sd_n     = dir_r != DIR_IDLE && n == '0;
                sweeps_n = (sd_n && !(&sweeps)) ? sweeps + SW'(1) : sweeps;
            end else if (same) begin
                step_e = count != '0;
                dir_n  = count == '0 ? DIR_IDLE : dir_r;
            end else begin
                step_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            count      <= '0;
            dir_r      <= DIR_IDLE;
            turn_level <= '0;
            sweeps     <= '0;
            turn       <= 1'b0;
            kickback   <= 1'b0;
            sweep_done <= 1'b0;
            err_code   <= 1'b0;
            err_step   <= 1'b0;
        end else begin
            led_q      <= led;
            count      <= count_n;
            dir_r      <= dir_n;
            turn_level <= tl_n;
            sweeps     <= sweeps_n;
            turn       <= turn_n;
            kickback   <= kick_n;
            sweep_done <= sd_n;
            // A fresh error outranks a simultaneous clear.
            err_code   <= (err_code & ~clear_err) | ~valid;
            err_step   <= (err_step & ~clear_err) | step_e;
        end
    end
endmodule

// File: tb/tb_led_seq_monitor.sv
// tb_led_seq_monitor: scoreboard bench for led_seq_monitor against a behavioural sweep model.
module tb_led_seq_monitor;
    typedef struct packed {
        logic [4:0] cnt;
        logic [1:0] dir;
        logic       turn;
        logic [4:0] tl;
        logic       kick;
        logic       sd;
        logic [7:0] sw;
        logic       ec;
        logic       es;
    } obs_t;

    typedef struct {
        obs_t o;
        int   due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] led = '0;
    logic        clear_err = 1'b0;
    logic [4:0]  count, turn_level;
    logic [1:0]  dir;
    logic        turn, kickback, sweep_done, err_code, err_step;
    logic [7:0]  sweeps;

    int   errors = 0;
    int   checks = 0;
    int   ecnt = 0;
    bit   next_clr = 1'b0;
    exp_t q[$];

    int m_cnt = 0, m_dir = 0, m_tl = 0, m_sw = 0;
    bit m_ec = 0, m_es = 0;

    led_seq_monitor dut (
        .clk(clk), .rst_n(rst_n), .led(led), .clear_err(clear_err),
        .count(count), .dir(dir), .turn(turn), .turn_level(turn_level),
        .kickback(kickback), .sweep_done(sweep_done), .sweeps(sweeps),
        .err_code(err_code), .err_step(err_step)
    );

    always #5 clk = ~clk;

    obs_t got;
    assign got = '{count, dir, turn, turn_level, kickback, sweep_done, sweeps, err_code, err_step};

    function automatic logic [15:0] therm(input int n);
        logic [31:0] t;
        t = (32'd1 << n) - 32'd1;
        return t[15:0];
    endfunction

    // Reference: find n with led == 2^n-1, then apply the sweep rules on the signed step.
    task automatic model(input logic [15:0] v, input bit c, output obs_t o);
        int n = -1;
        int d;
        bit ne = 0, se = 0;
        o = '0;
        for (int i = 0; i <= 16; i++) if (32'(v) == (32'd1 << i) - 32'd1) n = i;
        if (n < 0) ne = 1;
        else begin
            d = n - m_cnt;
            if (d == 1) begin
                if (m_dir == 2) begin
                    o.turn = 1;
                    m_tl = m_cnt;
                    o.kick = m_cnt > 0;
                end
                m_dir = 1;
            end else if (d == -1) begin
                if (m_dir == 0) se = 1;
                else begin
                    if (m_dir == 1) begin
                        o.turn = 1;
                        m_tl = m_cnt;
                    end
                    m_dir = 2;
                    if (n == 0) begin
                        o.sd = 1;
                        if (m_sw < 255) m_sw++;
                        m_dir = 0;
                    end
                end
            end else if (d == 0 && m_cnt == 0) m_dir = 0;
            else se = 1;
            m_cnt = n;
        end
        m_ec = (m_ec && !c) || ne;
        m_es = (m_es && !c) || se;
        o.cnt = 5'(m_cnt);
        o.dir = 2'(m_dir);
        o.tl  = 5'(m_tl);
        o.sw  = 8'(m_sw);
        o.ec  = m_ec;
        o.es  = m_es;
    endtask

    // Sample v is judged together with the clear driven one cycle later,
    // because the state update lags the bus by one register.
    task automatic step(input logic [15:0] v, input bit c);
        exp_t e;
        @(negedge clk);
        clear_err = next_clr;
        led = v;
        next_clr = c;
        model(v, c, e.o);
        e.due = ecnt + 2;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        led = '0;
        clear_err = 1'b0;
        next_clr = 1'b0;
        #1;
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset: got %h required 0 (count=%0d dir=%0d sweeps=%0d)", got, count, dir, sweeps);
        end
        q.delete();
        m_cnt = 0; m_dir = 0; m_tl = 0; m_sw = 0; m_ec = 0; m_es = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        ecnt++;
        while (q.size() > 0 && q[0].due <= ecnt) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.due != ecnt || got !== e.o)
                begin
                    errors++;
                    $display("FAIL outputs edge %0d: got cnt=%0d dir=%0d turn=%0d tl=%0d kick=%0d sd=%0d sw=%0d ec=%0d es=%0d, required cnt=%0d dir=%0d turn=%0d tl=%0d kick=%0d sd=%0d sw=%0d ec=%0d es=%0d",
                             ecnt, got.cnt, got.dir, got.turn, got.tl, got.kick, got.sd, got.sw, got.ec, got.es,
                             e.o.cnt, e.o.dir, e.o.turn, e.o.tl, e.o.kick, e.o.sd, e.o.sw, e.o.ec, e.o.es);
                end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        repeat (3) step(16'h0000, 0);
        for (int n = 1; n <= 16; n++) step(therm(n), 0);
        for (int n = 15; n >= 0; n--) step(therm(n), 0);
        for (int n = 1; n <= 6; n++) step(therm(n), 0);
        step(therm(5), 0);
        step(therm(6), 0);
        for (int n = 5; n >= 0; n--) step(therm(n), 0);
        for (int n = 1; n <= 3; n++) step(therm(n), 0);
        step(16'h0005, 0);
        step(16'h000F, 0);
        for (int n = 3; n >= 0; n--) step(therm(n), 0);
        step(16'h0001, 0);
        step(16'h0003, 0);
        step(16'h00FF, 0);
        step(therm(7), 1);
        step(therm(6), 0);
        step(therm(2), 1);
        step(therm(1), 0);
        step(therm(0), 0);
        for (int n = 1; n <= 9; n++) step(therm(n), 0);
        do_reset();
        step(therm(3), 0);
        step(therm(2), 0);
        step(therm(1), 0);
        step(therm(0), 1);
        step(therm(0), 0);
        for (int i = 0; i < 260; i++) begin
            step(therm(1), 0);
            step(therm(0), 0);
        end
        for (int i = 0; i < 3000; i++) begin
            int r;
            int t;
            logic [15:0] v;
            r = int'($urandom_range(0, 99));
            if (r < 75) begin
                t = m_cnt + (($urandom_range(0, 1) == 1) ? 1 : -1);
                if (t < 0) t = 0;
                if (t > 16) t = 15;
                v = therm(t);
            end else if (r < 85) v = therm(m_cnt);
            else if (r < 93) v = 16'($urandom);
            else v = therm(int'($urandom_range(0, 16)));
            step(v, $urandom_range(0, 19) == 0);
        end
        step(16'h0000, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
